// File: rtl/wall_map.sv
// Arena wall tile map: per-spot tile lookup with one-clock lookahead, power-up
// init sequencer, game-logic write port and a four-slot crumble animator.
module wall_map #(
  parameter int COLS        = 15,
  parameter int ROWS        = 13,
  parameter int ORIGIN_X    = 160,
  parameter int ORIGIN_Y    = 92,
  parameter int ANIM_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic               frame_tick,
  input  logic               reinit,
  input  logic               wr_req,
  input  logic [3:0]         wr_col,
  input  logic [3:0]         wr_row,
  input  logic [3:0]         wr_code,
  input  logic               wr_destroy,
  output logic               wr_ack,
  output logic               busy,
  output logic [10:0]        centerXW,
  output logic [10:0]        centerYW,
  output logic [3:0]         sprite_num,
  output logic               o_dbg_state
);
  localparam int NT = COLS * ROWS;
  localparam int CW = $clog2(ANIM_FRAMES + 1);
  localparam logic [10:0] OFF_SCREEN = 11'h7C0;

  typedef enum logic {S_IDLE = 1'b0, S_INIT = 1'b1} state_t;

  state_t                r_state;
  logic                  r_busy, r_ack;
  logic [7:0]            r_iaddr;
  logic [3:0]            r_icol, r_irow;
  logic [3:0]            r_sv, r_sp;
  logic [3:0][7:0]       r_sa;
  logic [3:0][1:0]       r_ss;
  logic [3:0][CW-1:0]    r_sc;
  logic [3:0]            r_mem [NT];
  logic [3:0]            r_rd;
  logic                  r_hit;
  logic [10:0]           r_cx, r_cy;

  logic signed [10:0]    w_dx, w_dy, w_tx, w_ty;
  logic                  w_in, w_show;
  logic [7:0]            w_raddr;

  // Lookahead: resolve the tile one pixel ahead so registered outputs line up.
  assign w_dx = spotX + 11'sd1 - $signed(11'(ORIGIN_X));
  assign w_dy = spotY - $signed(11'(ORIGIN_Y));
  assign w_tx = w_dx >>> 5;
  assign w_ty = w_dy >>> 5;
  assign w_in = !w_tx[10] && (w_tx < $signed(11'(COLS))) &&
                !w_ty[10] && (w_ty < $signed(11'(ROWS)));
  assign w_raddr = w_in ? (8'(w_ty[3:0]) * 8'(COLS) + 8'(w_tx[3:0])) : 8'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit <= 1'b0;
      r_cx  <= '0;
      r_cy  <= '0;
    end else begin
      r_hit <= w_in;
      r_cx  <= 11'(ORIGIN_X) + {2'b00, w_tx[3:0], 5'b0};
      r_cy  <= 11'(ORIGIN_Y) + {2'b00, w_ty[3:0], 5'b0};
    end
  end

  // Codes 7..14 are not drawable and fall through to the empty-tile output.
  assign w_show     = r_hit && (r_rd <= 4'd6);
  assign centerXW   = w_show ? r_cx : OFF_SCREEN;
  assign centerYW   = w_show ? r_cy : OFF_SCREEN;
  assign sprite_num = w_show ? r_rd : 4'd15;
  assign wr_ack     = r_ack;
  assign busy       = r_busy;
  assign o_dbg_state = r_state;

  logic [3:0] w_icode;
  always_comb begin
    w_icode = 4'd15;
    if (r_irow == 4'd0 || r_irow == 4'(ROWS - 1) || r_icol == 4'd0 || r_icol == 4'(COLS - 1))
      w_icode = 4'd0;
    else if (!r_irow[0] && !r_icol[0])
      w_icode = 4'd1;
  end

  logic [7:0] w_haddr;
  logic       w_hin;
  assign w_haddr = 8'(wr_row) * 8'(COLS) + 8'(wr_col);
  assign w_hin   = ({1'b0, wr_col} < 5'(COLS)) && ({1'b0, wr_row} < 5'(ROWS));

  logic [3:0]         w_sv, w_sp, w_due;
  logic [3:0][7:0]    w_sa;
  logic [3:0][1:0]    w_ss;
  logic [3:0][CW-1:0] w_sc;
  logic               w_we, w_take, w_svc, w_fhit, w_mhit;
  logic [7:0]         w_waddr;
  logic [3:0]         w_wdata;
  logic [1:0]         w_sidx, w_fidx;

  always_comb begin
    w_sv = r_sv; w_sa = r_sa; w_ss = r_ss; w_sc = r_sc; w_due = '0;
    w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_take = 1'b0;
    w_svc = 1'b0; w_sidx = '0; w_fhit = 1'b0; w_fidx = '0; w_mhit = 1'b0;
    // A slot already waiting to write 15 stops counting until it is retired.
    for (int i = 0; i < 4; i++) begin
      if (frame_tick && r_sv[i] && r_ss[i] != 2'd3) begin
        if (r_sc[i] == CW'(ANIM_FRAMES - 1)) begin
          w_sc[i]  = '0;
          w_ss[i]  = r_ss[i] + 2'd1;
          w_due[i] = 1'b1;
        end else begin
          w_sc[i] = r_sc[i] + CW'(1);
        end
      end
    end
    w_sp = r_sp | w_due;
    for (int i = 0; i < 4; i++) begin
      if (r_sp[i] && !w_svc) begin w_svc = 1'b1; w_sidx = 2'(i); end
      if (!r_sv[i] && !w_fhit) begin w_fhit = 1'b1; w_fidx = 2'(i); end
      if (r_sv[i] && r_sa[i] == w_haddr) w_mhit = 1'b1;
    end
    if (reinit) begin
      w_we = 1'b0;
    end else if (r_state == S_INIT) begin
      w_we = 1'b1; w_waddr = r_iaddr; w_wdata = w_icode;
    end else if (w_svc) begin
      w_we    = 1'b1;
      w_waddr = r_sa[w_sidx];
      w_wdata = (r_ss[w_sidx] == 2'd3) ? 4'd15 : 4'd4 + {2'b00, r_ss[w_sidx]};
      w_sp[w_sidx] = w_due[w_sidx];
      if (r_ss[w_sidx] == 2'd3) w_sv[w_sidx] = 1'b0;
    end else if (wr_req && !r_ack) begin
      w_take = 1'b1;
      if (w_hin && !wr_destroy) begin
        w_we = 1'b1; w_waddr = w_haddr; w_wdata = wr_code;
        for (int i = 0; i < 4; i++)
          if (r_sv[i] && r_sa[i] == w_haddr) begin w_sv[i] = 1'b0; w_sp[i] = 1'b0; end
      end else if (w_hin && !w_mhit) begin
        w_we = 1'b1; w_waddr = w_haddr;
        if (w_fhit) begin
          w_wdata = 4'd4;
          w_sv[w_fidx] = 1'b1; w_sa[w_fidx] = w_haddr;
          w_ss[w_fidx] = 2'd0; w_sc[w_fidx] = '0; w_sp[w_fidx] = 1'b0;
        end else begin
          w_wdata = 4'd15;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
      r_iaddr <= '0;
      r_icol  <= '0;
      r_irow  <= '0;
      r_sv    <= '0;
      r_sp    <= '0;
      r_sa    <= '0;
      r_ss    <= '0;
      r_sc    <= '0;
    end else begin
      r_ack <= w_take;
      if (reinit) begin
        r_state <= S_INIT;
        r_busy  <= 1'b1;
        r_iaddr <= '0;
        r_icol  <= '0;
        r_irow  <= '0;
        r_sv    <= '0;
        r_sp    <= '0;
      end else begin
        r_sv <= w_sv; r_sp <= w_sp; r_sa <= w_sa; r_ss <= w_ss; r_sc <= w_sc;
        case (r_state)
          S_INIT: begin
            if (r_iaddr == 8'(NT - 1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_iaddr <= r_iaddr + 8'd1;
              if (r_icol == 4'(COLS - 1)) begin
                r_icol <= '0;
                r_irow <= r_irow + 4'd1;
              end else begin
                r_icol <= r_icol + 4'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wall_map.sv
// Randomised scoreboard bench for wall_map: a tile-level arena model predicts
// display lookups and host-write effects; monitors compare as outputs appear.
module tb_wall_map;
  localparam int AF    = 2;
  localparam int NCOL  = 15;
  localparam int NROW  = 13;
  localparam int OX    = 160;
  localparam int OY    = 92;
  localparam logic [25:0] NONE = {11'h7C0, 11'h7C0, 4'hF};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [10:0] spotX = '0, spotY = '0;
  logic frame_tick = 1'b0, reinit = 1'b0, wr_req = 1'b0, wr_destroy = 1'b0;
  logic [3:0] wr_col = '0, wr_row = '0, wr_code = '0;
  logic wr_ack, busy, dbg_state;
  logic [10:0] centerXW, centerYW;
  logic [3:0] sprite_num;

  wall_map #(.ANIM_FRAMES(AF)) dut (
    .clk(clk), .reset_n(reset_n), .spotX(spotX), .spotY(spotY),
    .frame_tick(frame_tick), .reinit(reinit), .wr_req(wr_req),
    .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code), .wr_destroy(wr_destroy),
    .wr_ack(wr_ack), .busy(busy), .centerXW(centerXW), .centerYW(centerYW),
    .sprite_num(sprite_num), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [25:0] exp_q[$];
  int ack_q[$];
  int mmap[NCOL*NROW];
  int sl_addr[$], sl_code[$], sl_ticks[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int init_code(input int c, input int r);
    if (r == 0 || r == NROW-1 || c == 0 || c == NCOL-1) return 0;
    if (r % 2 == 0 && c % 2 == 0) return 1;
    return 15;
  endfunction

  task automatic model_reinit();
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) mmap[r*NCOL+c] = init_code(c, r);
    sl_addr.delete(); sl_code.delete(); sl_ticks.delete();
  endtask

  function automatic logic [25:0] exp_disp(input int x, input int y);
    int dx, dy, c, r, code;
    logic [10:0] cx, cy;
    dx = x - OX; dy = y - OY;
    if (dx < 0 || dy < 0 || dx >= 32*NCOL || dy >= 32*NROW) return NONE;
    c = dx / 32; r = dy / 32;
    code = mmap[r*NCOL+c];
    if (code > 6) return NONE;
    cx = 11'(OX + 32*c); cy = 11'(OY + 32*r);
    return {cx, cy, 4'(code)};
  endfunction

  task automatic model_apply(input int col, input int row, input int code, input bit destroy);
    int a, idx;
    if (col >= NCOL || row >= NROW) return;
    a = row*NCOL + col; idx = -1;
    foreach (sl_addr[i]) if (sl_addr[i] == a) idx = i;
    if (!destroy) begin
      mmap[a] = code;
      if (idx >= 0) begin sl_addr.delete(idx); sl_code.delete(idx); sl_ticks.delete(idx); end
    end else if (idx < 0) begin
      if (sl_addr.size() < 4) begin
        sl_addr.push_back(a); sl_code.push_back(4); sl_ticks.push_back(0); mmap[a] = 4;
      end else mmap[a] = 15;
    end
  endtask

  task automatic model_tick();
    foreach (sl_addr[i]) begin
      sl_ticks[i]++;
      if (sl_ticks[i] == AF) begin
        sl_ticks[i] = 0;
        sl_code[i] = (sl_code[i] == 6) ? 15 : sl_code[i] + 1;
        mmap[sl_addr[i]] = sl_code[i];
      end
    end
    for (int i = sl_addr.size()-1; i >= 0; i--)
      if (sl_code[i] == 15) begin sl_addr.delete(i); sl_code.delete(i); sl_ticks.delete(i); end
  endtask

  // Spot driven now is looked up one pixel ahead; the result appears after the edge.
  task automatic drive_spot(input int s, input int y);
    @(negedge clk);
    spotX = 11'(s); spotY = 11'(y);
    exp_q.push_back(exp_disp(s + 1, y));
  endtask

  task automatic spot_check(input int x, input int y);
    drive_spot(x - 1, y);
    repeat (2) @(negedge clk);
  endtask

  task automatic tile_check(input int c, input int r);
    spot_check(OX + 32*c + $urandom_range(0, 31), OY + 32*r + $urandom_range(0, 31));
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    model_tick();
    repeat (6) @(negedge clk);
  endtask

  task automatic host_write(input int col, input int row, input int code,
                            input bit destroy, output int lat);
    @(negedge clk);
    wr_col = 4'(col); wr_row = 4'(row); wr_code = 4'(code);
    wr_destroy = destroy; wr_req = 1'b1;
    ack_q.push_back(col*16 + row);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (wr_ack !== 1'b1 && lat < 2000);
    wr_req = 1'b0;
    if (wr_ack !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: no wr_ack within %0d clks", lat);
    end else begin
      model_apply(col, row, code, destroy);
      @(posedge clk); #1;
      check("ack_pulse", 32'(wr_ack), 32'd0);
    end
  endtask

  always begin : mon_disp
    logic [25:0] e;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("disp", {6'd0, centerXW, centerYW, sprite_num}, {6'd0, e});
    end
  end

  always begin : mon_ack
    @(posedge clk); #1;
    if (wr_ack === 1'b1) begin
      check("ack_expected", 32'(ack_q.size() > 0), 32'd1);
      if (ack_q.size() > 0) void'(ack_q.pop_front());
    end
  end

  initial begin
    int cnt, lat;
    model_reinit();
    // Reset values and init length
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_disp", {6'd0, centerXW, centerYW, sprite_num}, {6'd0, NONE});
    reset_n = 1'b1;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (busy && cnt < 1000);
    check("init_busy_clks", 32'(cnt), 32'd195);
    tile_check(0, 0); tile_check(2, 2); tile_check(1, 1); tile_check(14, 12);

    // Row sweep across the first tile boundary
    for (int s = 158; s <= 192; s++) drive_spot(s, 92);
    repeat (2) @(negedge clk);
    spot_check(192, 124); spot_check(100, 50);

    // Host plain write
    host_write(1, 1, 2, 1'b0, lat);
    check("idle_ack_latency", 32'(lat), 32'd1);
    spot_check(192, 124);

    // Single crumble
    host_write(3, 1, 0, 1'b1, lat);
    tile_check(3, 1);
    for (int k = 0; k < 3; k++) begin tick(); tick(); tile_check(3, 1); end

    // Five destroys: four slots animate, fifth goes straight to empty
    for (int k = 0; k < 5; k++) host_write(2 + 2*k, 2, 0, 1'b1, lat);
    for (int k = 0; k < 5; k++) tile_check(2 + 2*k, 2);
    host_write(2, 2, 0, 1'b1, lat);
    tick(); tick();
    for (int k = 0; k < 4; k++) tile_check(2 + 2*k, 2);
    host_write(4, 2, 2, 1'b0, lat);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 4; k++) tile_check(2 + 2*k, 2);

    // Randomised plain writes, including out-of-range targets
    for (int k = 0; k < 20; k++) begin
      host_write($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, lat);
      spot_check($urandom_range(120, 660), $urandom_range(60, 520));
      tile_check($urandom_range(0, NCOL-1), $urandom_range(0, NROW-1));
    end

    // Host request held off by a re-init
    @(negedge clk); reinit = 1'b1;
    @(negedge clk); reinit = 1'b0;
    model_reinit();
    check("reinit_busy", 32'(busy), 32'd1);
    host_write(1, 1, 3, 1'b0, lat);
    check("held_during_init", 32'(lat >= 195), 32'd1);
    check("busy_after_held", 32'(busy), 32'd0);
    spot_check(192, 124);

    // Reset mid-animation clears slots and reruns init
    host_write(4, 4, 0, 1'b1, lat);
    tile_check(4, 4);
    tick();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_disp", {6'd0, centerXW, centerYW, sprite_num}, {6'd0, NONE});
    reset_n = 1'b1;
    model_reinit();
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (busy && cnt < 1000);
    check("reinit_busy_clks", 32'(cnt), 32'd195);
    tile_check(4, 4);
    for (int k = 0; k < 4; k++) tick();
    tile_check(4, 4);

    repeat (4) @(negedge clk);
    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
